// File: rtl/axis_pkg.sv
// Shared AXI-stream helper package: ASCII control characters used by the
// stream formatters that feed the RS-232 transmitter.
package axis_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

endpackage

// File: rtl/axis_hex_formatter_hex_digit.sv
// hex_digit: converts one nibble into its ASCII hex digit.
// Purely combinational; uppercase selects 'A'-'F' over 'a'-'f'.
module hex_digit (
    input  logic [3:0] value,
    input  logic       uppercase,
    output logic [7:0] ascii
);

    // '0'-'9' sit at 8'h30; letters are offset so that value 10 lands on 'A' or 'a'
    always_comb begin
        if (value < 4'd10) begin
            ascii = 8'h30 + {4'h0, value};
        end else begin
            ascii = (uppercase ? 8'h37 : 8'h57) + {4'h0, value};
        end
    end

endmodule

// File: rtl/axis_hex_formatter.sv
// axis_hex_formatter: turns a byte stream into printable hex text.
// Each byte becomes two hex digits followed by a space, or by CR LF when the
// byte completes a line of PER_LINE bytes.
// Optional feature: define AXIS_HEX_FORMATTER_TLAST_EN to add an ilast input
// that forces CR LF after the flagged byte and restarts the column.
//
// state | meaning
// IDLE  | waiting for an input byte, iready high, ovalid low
// HI    | presenting the high-nibble digit
// LO    | presenting the low-nibble digit
// SEP   | presenting the space separator
// CR    | presenting carriage return
// LF    | presenting line feed
module axis_hex_formatter
    import axis_pkg::*;
#(
    parameter int PER_LINE  = 16,
    parameter int UPPERCASE = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata,
    input  logic       ivalid,
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
    input  logic       ilast,
`endif
    output logic       iready,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready
);

    localparam int               COL_W    = $clog2(PER_LINE + 1);
    localparam logic [COL_W-1:0] LINE_END = COL_W'(PER_LINE);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic             UC       = (UPPERCASE != 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        SEP  = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic             iready_r, iready_nxt;
    logic             ovalid_r, ovalid_nxt;
    logic [7:0]       odata_r, odata_nxt;
    logic [COL_W-1:0] column, column_nxt;
    logic [7:0]       hold, hold_nxt;
    logic             line_end;
    logic             in_xfer;
    logic             out_xfer;
    logic [3:0]       hi_nib;
    logic [7:0]       hi_char;
    logic [7:0]       lo_char;
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
    logic             hold_last, hold_last_nxt;
`endif

    assign in_xfer  = ivalid & iready_r;
    assign out_xfer = ovalid_r & oready;

`ifdef AXIS_HEX_FORMATTER_TLAST_EN
    assign line_end = (column == LINE_END) | hold_last;
`else
    assign line_end = (column == LINE_END);
`endif

    // In IDLE the high digit comes straight from idata so it can be registered
    // in the transfer cycle; afterwards it is regenerated from the holding register.
    assign hi_nib = (state == IDLE) ? idata[7:4] : hold[7:4];

    hex_digit u_hi_digit (
        .value     (hi_nib),
        .uppercase (UC),
        .ascii     (hi_char)
    );

    hex_digit u_lo_digit (
        .value     (hold[3:0]),
        .uppercase (UC),
        .ascii     (lo_char)
    );

    // State, registered handshakes, output character, column and holding register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            iready_r  <= 1'b0;
            ovalid_r  <= 1'b0;
            odata_r   <= 8'h00;
            column    <= '0;
            hold      <= 8'h00;
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
            hold_last <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            iready_r  <= iready_nxt;
            ovalid_r  <= ovalid_nxt;
            odata_r   <= odata_nxt;
            column    <= column_nxt;
            hold      <= hold_nxt;
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
            hold_last <= hold_last_nxt;
`endif
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt     = state;
        odata_nxt     = odata_r;
        column_nxt    = column;
        hold_nxt      = hold;
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
        hold_last_nxt = hold_last;
`endif
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    state_nxt  = HI;
                    hold_nxt   = idata;
                    column_nxt = column + COL_ONE;
                    odata_nxt  = hi_char;
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
                    hold_last_nxt = ilast;
`endif
                end
            end
            HI: begin
                if (out_xfer) begin
                    state_nxt = LO;
                    odata_nxt = lo_char;
                end else begin
                    odata_nxt = hi_char;
                end
            end
            LO: begin
                if (out_xfer) begin
                    if (line_end) begin
                        state_nxt  = CR;
                        odata_nxt  = CHAR_CR;
                        column_nxt = '0;
                    end else begin
                        state_nxt  = SEP;
                        odata_nxt  = CHAR_SPACE;
                    end
                end
            end
            SEP: begin
                if (out_xfer) begin
                    state_nxt = IDLE;
                end
            end
            CR: begin
                if (out_xfer) begin
                    state_nxt = LF;
                    odata_nxt = CHAR_LF;
                end
            end
            LF: begin
                if (out_xfer) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        iready_nxt = (state_nxt == IDLE);
        ovalid_nxt = (state_nxt != IDLE);
    end

    assign iready = iready_r;
    assign ovalid = ovalid_r;
    assign odata  = odata_r;

endmodule

// File: tb/tb_axis_hex_formatter.sv
// Testbench for axis_hex_formatter: two instances (PER_LINE=16 uppercase and
// PER_LINE=4 lowercase) checked by queue-based scoreboards.
module tb_axis_hex_formatter;

    logic       clock;
    logic       resetn;
    logic [7:0] idata_a, idata_b;
    logic       ivalid_a, ivalid_b;
    logic       ilast_a;
    logic       iready_a, iready_b;
    logic [7:0] odata_a, odata_b;
    logic       ovalid_a, ovalid_b;
    logic       oready_a, oready_b;

    int checks = 0;
    int errors = 0;
    int col_a  = 0;
    int col_b  = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    logic       pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
    logic [7:0] pd_a = 8'h00, pd_b = 8'h00;

    axis_hex_formatter #(.PER_LINE(16), .UPPERCASE(1)) dut_a (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata_a),
        .ivalid (ivalid_a),
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
        .ilast  (ilast_a),
`endif
        .iready (iready_a),
        .odata  (odata_a),
        .ovalid (ovalid_a),
        .oready (oready_a)
    );

    axis_hex_formatter #(.PER_LINE(4), .UPPERCASE(0)) dut_b (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata_b),
        .ivalid (ivalid_b),
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
        .ilast  (1'b0),
`endif
        .iready (iready_b),
        .odata  (odata_b),
        .ovalid (ovalid_b),
        .oready (oready_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %02h required %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] v, input bit upper);
        if (v < 10) return 8'h30 + 8'(v);
        return (upper ? 8'h41 : 8'h61) + 8'(v) - 8'd10;
    endfunction

    // Model: push the expected characters for one byte
    task automatic push_line(input bit sel, input logic [7:0] d, input bit last);
        bit brk;
        if (!sel) begin
            qa.push_back(hexc(d[7:4], 1'b1));
            qa.push_back(hexc(d[3:0], 1'b1));
            col_a++;
            brk = (col_a == 16);
`ifdef AXIS_HEX_FORMATTER_TLAST_EN
            brk = brk || last;
`endif
            if (brk) begin
                qa.push_back(8'h0D); qa.push_back(8'h0A); col_a = 0;
            end else qa.push_back(8'h20);
        end else begin
            qb.push_back(hexc(d[7:4], 1'b0));
            qb.push_back(hexc(d[3:0], 1'b0));
            col_b++;
            if (col_b == 4) begin
                qb.push_back(8'h0D); qb.push_back(8'h0A); col_b = 0;
            end else qb.push_back(8'h20);
        end
    endtask

    // Drive one byte; returns 1 ns after the posedge at which it transferred
    task automatic send(input bit sel, input logic [7:0] d, input bit last);
        bit done = 1'b0;
        @(posedge clock); #1;
        if (sel) begin ivalid_b = 1'b1; idata_b = d; end
        else begin ivalid_a = 1'b1; idata_a = d; ilast_a = last; end
        for (int i = 0; i < 200 && !done; i++) begin
            if (sel ? iready_b : iready_a) done = 1'b1;
            @(posedge clock); #1;
        end
        if (sel) begin ivalid_b = 1'b0; idata_b = 8'hEE; end
        else begin ivalid_a = 1'b0; idata_a = 8'hEE; ilast_a = 1'b0; end
        chk("send_accepted", 8'(done), 8'h01);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clock);
            if (qa.size() == 0 && qb.size() == 0 && !ovalid_a && !ovalid_b) done = 1'b1;
        end
        chk("drain", 8'(done), 8'h01);
    endtask

    // Monitor / scoreboard: stall stability and in-order character comparison
    always @(negedge clock) begin
        logic [7:0] e;
        if (resetn) begin
            if (pv_a && !pr_a) begin
                chk("stall_valid_a", 8'(ovalid_a), 8'h01);
                chk("stall_data_a", odata_a, pd_a);
            end
            if (ovalid_a && oready_a) begin
                if (qa.size() == 0) chk("unexpected_char_a", odata_a, 8'hxx);
                else begin e = qa.pop_front(); chk("char_a", odata_a, e); end
            end
            if (pv_b && !pr_b) begin
                chk("stall_valid_b", 8'(ovalid_b), 8'h01);
                chk("stall_data_b", odata_b, pd_b);
            end
            if (ovalid_b && oready_b) begin
                if (qb.size() == 0) chk("unexpected_char_b", odata_b, 8'hxx);
                else begin e = qb.pop_front(); chk("char_b", odata_b, e); end
            end
        end
        pv_a = resetn & ovalid_a; pr_a = oready_a; pd_a = odata_a;
        pv_b = resetn & ovalid_b; pr_b = oready_b; pd_b = odata_b;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual running required finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        ivalid_a = 1'b0; ivalid_b = 1'b0; ilast_a = 1'b0;
        idata_a = 8'h00; idata_b = 8'h00;
        oready_a = 1'b1; oready_b = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_iready_a", 8'(iready_a), 8'h00);
        chk("rst_ovalid_a", 8'(ovalid_a), 8'h00);
        chk("rst_odata_a", odata_a, 8'h00);
        chk("rst_iready_b", 8'(iready_b), 8'h00);
        chk("rst_ovalid_b", 8'(ovalid_b), 8'h00);
        @(posedge clock); #1 resetn = 1'b1;
        @(negedge clock);
        chk("iready_before_first_clk", 8'(iready_a), 8'h00);
        @(negedge clock);
        chk("iready_after_release_a", 8'(iready_a), 8'h01);
        chk("iready_after_release_b", 8'(iready_b), 8'h01);

        // A5: latency, character sequence, iready low until the space transfers
        push_line(0, 8'hA5, 0);
        send(0, 8'hA5, 0);
        @(negedge clock);
        chk("a5_lat_ovalid", 8'(ovalid_a), 8'h01);
        chk("a5_hi", odata_a, 8'h41);
        chk("a5_iready1", 8'(iready_a), 8'h00);
        @(negedge clock);
        chk("a5_lo", odata_a, 8'h35);
        chk("a5_iready2", 8'(iready_a), 8'h00);
        @(negedge clock);
        chk("a5_sep", odata_a, 8'h20);
        chk("a5_iready3", 8'(iready_a), 8'h00);
        @(negedge clock);
        chk("a5_idle_ovalid", 8'(ovalid_a), 8'h00);
        chk("a5_idle_iready", 8'(iready_a), 8'h01);

        // Stall of 7 cycles with the low digit pending
        push_line(0, 8'h7C, 0);
        send(0, 8'h7C, 0);
        @(posedge clock); #1 oready_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk("stall_lo_char", odata_a, 8'h43);
            chk("stall_lo_valid", 8'(ovalid_a), 8'h01);
            @(posedge clock);
        end
        #1 oready_a = 1'b1;
        drain();

        // PER_LINE=4 wrap, lowercase digits
        for (int i = 0; i < 5; i++) begin
            push_line(1, 8'(i), 0);
            send(1, 8'(i), 0);
        end
        push_line(1, 8'h3F, 0);
        send(1, 8'h3F, 0);
        push_line(1, 8'h05, 0);
        send(1, 8'h05, 0);
        drain();

        // Reset after the HI digit of byte 06 transfers
        qb.push_back(8'h30);
        send(1, 8'h06, 0);
        @(posedge clock); #1 resetn = 1'b0;
        #1;
        chk("midrst_ovalid_b", 8'(ovalid_b), 8'h00);
        chk("midrst_iready_b", 8'(iready_b), 8'h00);
        chk("midrst_iready_a", 8'(iready_a), 8'h00);
        chk("midrst_flush_b", 8'(qb.size()), 8'h00);
        qb.delete();
        col_a = 0; col_b = 0;
        @(posedge clock); @(posedge clock); #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_line(1, 8'h12 + 8'(i), 0);
            send(1, 8'h12 + 8'(i), 0);
        end
        drain();

        // Column 2, then FF flagged last, then a full line on the 16-byte instance
        push_line(0, 8'h20, 0); send(0, 8'h20, 0);
        push_line(0, 8'h21, 0); send(0, 8'h21, 0);
        push_line(0, 8'hFF, 1); send(0, 8'hFF, 1);
        for (int i = 0; i < 16; i++) begin
            push_line(0, 8'h80 + 8'(i), 0);
            send(0, 8'h80 + 8'(i), 0);
        end
        drain();

        chk("final_qa_empty", 8'(qa.size()), 8'h00);
        chk("final_qb_empty", 8'(qb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
